// File: rtl/axi_config_pkg.sv
// Shared types for the AXI-lite configuration loader: response codes, FSM states
// and the index-width helper used to size entry counters.
package axi_config_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_e;

    // IDLE only exists while reset is held; it launches entry 0 on release.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        RESP      = 3'd2,
        VERIFY_AR = 3'd3,
        VERIFY_R  = 3'd4,
        DONE      = 3'd5
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_config_loader_hold.sv
// One-flag AXI-lite valid holder: set when a transfer is issued, cleared on the
// ready handshake, so the valid never re-asserts for the same entry.
module axi_lite_hold (
    input  logic clk,
    input  logic srst,
    input  logic issue,
    input  logic ready,
    output logic valid
);

    logic valid_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_reg <= 1'b0;
        end else if (issue) begin
            valid_reg <= 1'b1;
        end else if (ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;

endmodule

// File: rtl/axi_config_loader.sv
// AXI-lite initiator replaying a compiled-in list of register writes after reset
// and on start. Define AXI_CONFIG_LOADER_VERIFY_EN to read back and compare each entry.
module axi_config_loader
    import axi_config_pkg::*;
#(
    parameter int N          = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    // Defaults only let the block elaborate on its own; real instances override them.
    parameter bit [ADDR_WIDTH-1:0] ADDR [N] = '{default: '0},
    parameter bit [DATA_WIDTH-1:0] DATA [N] = '{default: '0}
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      start,
    output logic                      done,
    output logic                      err,
    output logic [idx_width(N)-1:0]   err_idx,

    output logic                      m_axi_AWVALID,
    input  logic                      m_axi_AWREADY,
    output logic [ADDR_WIDTH-1:0]     m_axi_AWADDR,

    output logic                      m_axi_WVALID,
    input  logic                      m_axi_WREADY,
    output logic [DATA_WIDTH-1:0]     m_axi_WDATA,
    output logic [DATA_WIDTH/8-1:0]   m_axi_WSTRB,

    input  logic                      m_axi_BVALID,
    output logic                      m_axi_BREADY,
    input  logic [1:0]                m_axi_BRESP,

    output logic                      m_axi_ARVALID,
    input  logic                      m_axi_ARREADY,
    output logic [ADDR_WIDTH-1:0]     m_axi_ARADDR,

    input  logic                      m_axi_RVALID,
    output logic                      m_axi_RREADY,
    input  logic [DATA_WIDTH-1:0]     m_axi_RDATA,
    input  logic [1:0]                m_axi_RRESP
);

    localparam int               IDX_W    = idx_width(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_e           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             err_reg, err_next;
    logic [IDX_W-1:0] err_idx_reg, err_idx_next;
    logic             issue_write;
    logic             entry_done;
    logic             entry_bad;

    // Holder 0 drives AW, holder 1 drives W; both launch together.
    logic [1:0] wr_valid;
    logic [1:0] wr_ready;
    logic       wr_complete;

    assign wr_ready = {m_axi_WREADY, m_axi_AWREADY};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_wr_hold
            axi_lite_hold u_hold (
                .clk   (ap_clk),
                .srst  (ap_rst),
                .issue (issue_write),
                .ready (wr_ready[gi]),
                .valid (wr_valid[gi])
            );
        end
    endgenerate

    // A channel is finished when its valid already dropped or handshakes now.
    assign wr_complete = (!wr_valid[0] || wr_ready[0]) && (!wr_valid[1] || wr_ready[1]);

`ifdef AXI_CONFIG_LOADER_VERIFY_EN
    logic issue_ar;
    logic ar_valid;

    axi_lite_hold u_ar_hold (
        .clk   (ap_clk),
        .srst  (ap_rst),
        .issue (issue_ar),
        .ready (m_axi_ARREADY),
        .valid (ar_valid)
    );

    assign m_axi_ARVALID = ar_valid;
    assign m_axi_RREADY  = (state_reg == VERIFY_R);
`else
    logic unused_read_channel;

    assign unused_read_channel = ^{m_axi_ARREADY, m_axi_RVALID, m_axi_RDATA, m_axi_RRESP};
    assign m_axi_ARVALID       = 1'b0;
    assign m_axi_RREADY        = (state_reg != IDLE);
`endif

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            err_reg     <= 1'b0;
            err_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            err_reg     <= err_next;
            err_idx_reg <= err_idx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        err_next     = err_reg;
        err_idx_next = err_idx_reg;
        issue_write  = 1'b0;
        entry_done   = 1'b0;
        entry_bad    = 1'b0;
`ifdef AXI_CONFIG_LOADER_VERIFY_EN
        issue_ar     = 1'b0;
`endif

        case (state_reg)
            IDLE: begin
                state_next  = WRITE;
                issue_write = 1'b1;
            end
            WRITE: begin
                if (wr_complete) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (m_axi_BVALID) begin
                    entry_bad = (resp_e'(m_axi_BRESP) != OKAY);
`ifdef AXI_CONFIG_LOADER_VERIFY_EN
                    state_next = VERIFY_AR;
                    issue_ar   = 1'b1;
`else
                    entry_done = 1'b1;
`endif
                end
            end
`ifdef AXI_CONFIG_LOADER_VERIFY_EN
            VERIFY_AR: begin
                if (m_axi_ARREADY) begin
                    state_next = VERIFY_R;
                end
            end
            VERIFY_R: begin
                if (m_axi_RVALID) begin
                    entry_bad  = (resp_e'(m_axi_RRESP) != OKAY) || (m_axi_RDATA != DATA[idx_reg]);
                    entry_done = 1'b1;
                end
            end
`endif
            DONE: begin
                if (start) begin
                    state_next   = WRITE;
                    issue_write  = 1'b1;
                    idx_next     = '0;
                    err_next     = 1'b0;
                    err_idx_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Only the first failing entry of a sequence is recorded.
        if (entry_bad && !err_reg) begin
            err_next     = 1'b1;
            err_idx_next = idx_reg;
        end

        if (entry_done) begin
            if (idx_reg == LAST_IDX) begin
                state_next = DONE;
            end else begin
                idx_next    = idx_reg + 1'b1;
                state_next  = WRITE;
                issue_write = 1'b1;
            end
        end
    end

    assign m_axi_AWVALID = wr_valid[0];
    assign m_axi_WVALID  = wr_valid[1];
    assign m_axi_AWADDR  = ADDR[idx_reg];
    assign m_axi_WDATA   = DATA[idx_reg];
    assign m_axi_WSTRB   = {(DATA_WIDTH/8){1'b1}};
    assign m_axi_ARADDR  = ADDR[idx_reg];
    assign m_axi_BREADY  = (state_reg == RESP);

    assign done    = (state_reg == DONE);
    assign err     = err_reg;
    assign err_idx = err_idx_reg;

endmodule
